// File: rtl/fdivsqrt_seq_pkg.sv
// Shared definitions for the divide/sqrt iteration sequencer: state encoding
// and the step-counter width derived from the widest iteration count.
package fdivsqrt_seq_pkg;

  localparam int XLEN       = 64;
  localparam int LOGR       = 1;
  localparam int NF         = 52;
  // Double-precision significand plus integer, guard and rounding digits.
  localparam int FP_CYCLES  = NF + 4;
  localparam int INT_CYCLES = XLEN / LOGR;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYCLES = max_int(FP_CYCLES, INT_CYCLES);
  localparam int CNTW       = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {
    FDIV_IDLE = 2'd0,
    FDIV_BUSY = 2'd1,
    FDIV_DONE = 2'd2
  } fdivsqrt_state_t;

endpackage

// File: rtl/fdivsqrt_stepcnt.sv
// Loadable down-counter for the remaining iteration count. Clear beats load,
// load beats decrement, and a decrement at zero holds zero.
module fdivsqrt_stepcnt #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         is_one_o
);

  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = CNT_ZERO;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != CNT_ZERO)) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign is_one_o = (cnt_q == CNT_ONE);

endmodule

// File: rtl/fdivsqrt_seq.sv
// Iteration sequencer for the shared divide/sqrt datapath: start strobe,
// busy/done handshake, early exit on zero residual and special-case bypass.
module fdivsqrt_seq
  import fdivsqrt_seq_pkg::*;
#(
  parameter int CNTW = fdivsqrt_seq_pkg::CNTW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            FDivStartE,
  input  logic            IDivStartE,
  input  logic            StallM,
  input  logic            FlushE,
  input  logic            SpecialCaseE,
  input  logic            WZeroE,
  input  logic [CNTW-1:0] CyclesE,
  output logic            IFDivStartE,
  output logic            FDivBusyE,
  output logic            FDivDoneE,
  output logic            FirstIterE,
  output logic [CNTW-1:0] StepE
);

  localparam logic [CNTW-1:0] CYC_ZERO = {CNTW{1'b0}};
  localparam logic [CNTW-1:0] CYC_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

  fdivsqrt_state_t state_d;
  fdivsqrt_state_t state_q;
  logic            first_d;
  logic            first_q;

  logic            start_req;
  logic [CNTW-1:0] cycles_sat;
  logic            cnt_clr;
  logic            cnt_load;
  logic            cnt_dec;
  logic            step_is_one;

  // Both decoder sources collapse into one request.
  assign start_req  = FDivStartE | IDivStartE;
  assign cycles_sat = (CyclesE == CYC_ZERO) ? CYC_ONE : CyclesE;

  // State and first-iteration flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FDIV_IDLE;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
    end
  end

  // Next-state and step-counter control; flush overrides the state logic.
  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (FlushE) begin
      state_d = FDIV_IDLE;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        FDIV_IDLE: begin
          if (IFDivStartE && SpecialCaseE) begin
            state_d = FDIV_DONE;
            cnt_clr = 1'b1;
          end else if (IFDivStartE) begin
            state_d  = FDIV_BUSY;
            cnt_load = 1'b1;
          end else begin
            state_d = FDIV_IDLE;
          end
        end
        FDIV_BUSY: begin
          if (step_is_one || WZeroE) begin
            state_d = FDIV_DONE;
            cnt_clr = 1'b1;
          end else begin
            state_d = FDIV_BUSY;
            cnt_dec = 1'b1;
          end
        end
        FDIV_DONE: begin
          if (StallM) begin
            state_d = FDIV_DONE;
          end else begin
            state_d = FDIV_IDLE;
          end
        end
        default: begin
          state_d = FDIV_IDLE;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  // The first flag is only ever live for the BUSY cycle right after a start.
  always_comb begin
    first_d = 1'b0;
    if (FlushE) begin
      first_d = 1'b0;
    end else begin
      first_d = IFDivStartE & ~SpecialCaseE;
    end
  end

  // Handshake outputs derived from state and the live request.
  always_comb begin
    IFDivStartE = 1'b0;
    FDivBusyE   = 1'b0;
    FDivDoneE   = 1'b0;
    FirstIterE  = 1'b0;
    if (state_q == FDIV_IDLE) begin
      IFDivStartE = start_req & ~StallM & ~FlushE;
    end else begin
      IFDivStartE = 1'b0;
    end
    FDivBusyE  = (state_q == FDIV_BUSY) | IFDivStartE;
    FDivDoneE  = (state_q == FDIV_DONE);
    FirstIterE = (state_q == FDIV_BUSY) & first_q;
  end

  fdivsqrt_stepcnt #(
    .W(CNTW)
  ) u_stepcnt (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (cnt_clr),
    .load_i    (cnt_load),
    .load_val_i(cycles_sat),
    .dec_i     (cnt_dec),
    .cnt_o     (StepE),
    .is_one_o  (step_is_one)
  );

endmodule

// File: tb/tb_fdivsqrt_seq.sv
// Self-checking bench for fdivsqrt_seq: directed scenarios with literal
// expectations plus randomized traffic checked against a cycle model.
module tb_fdivsqrt_seq;

  localparam int CNTW = 7;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            fds = 1'b0;
  logic            ids = 1'b0;
  logic            stall = 1'b0;
  logic            flush = 1'b0;
  logic            special = 1'b0;
  logic            wz = 1'b0;
  logic [CNTW-1:0] cyc = '0;

  logic            IFDivStartE;
  logic            FDivBusyE;
  logic            FDivDoneE;
  logic            FirstIterE;
  logic [CNTW-1:0] StepE;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  // model: phase 0 = idle, 1 = iterating, 2 = result waiting
  int m_phase = 0;
  int m_step = 0;
  bit m_first = 1'b0;

  always #5 clk = ~clk;

  fdivsqrt_seq #(.CNTW(CNTW)) dut (
    .clk         (clk),
    .reset       (reset),
    .FDivStartE  (fds),
    .IDivStartE  (ids),
    .StallM      (stall),
    .FlushE      (flush),
    .SpecialCaseE(special),
    .WZeroE      (wz),
    .CyclesE     (cyc),
    .IFDivStartE (IFDivStartE),
    .FDivBusyE   (FDivBusyE),
    .FDivDoneE   (FDivDoneE),
    .FirstIterE  (FirstIterE),
    .StepE       (StepE)
  );

  function automatic bit exp_start();
    return (fds || ids) && (m_phase == 0) && !stall && !flush;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset || flush) begin
      m_phase <= 0;
      m_step  <= 0;
      m_first <= 1'b0;
    end else begin
      case (m_phase)
        0: begin
          if (exp_start()) begin
            if (special) begin
              m_phase <= 2;
              m_step  <= 0;
              m_first <= 1'b0;
            end else begin
              m_phase <= 1;
              m_step  <= (cyc == 0) ? 1 : int'(cyc);
              m_first <= 1'b1;
            end
          end
        end
        1: begin
          m_first <= 1'b0;
          if (m_step == 1 || wz) begin
            m_phase <= 2;
            m_step  <= 0;
          end else begin
            m_step <= m_step - 1;
          end
        end
        2: begin
          if (!stall) m_phase <= 0;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_start", 32'(IFDivStartE), 32'(exp_start()));
      chk("model_busy", 32'(FDivBusyE), 32'((m_phase == 1) || exp_start()));
      chk("model_done", 32'(FDivDoneE), 32'(m_phase == 2));
      chk("model_first", 32'(FirstIterE), 32'((m_phase == 1) && m_first));
      chk("model_step", 32'(StepE), 32'(m_step));
    end
  end

  task automatic apply(input bit r, input bit f, input bit i, input bit s, input bit fl,
                       input bit sp, input bit w, input int n);
    @(posedge clk);
    #1;
    reset = r; fds = f; ids = i; stall = s; flush = fl; special = sp; wz = w;
    cyc = n[CNTW-1:0];
    @(negedge clk);
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check_en = 1'b1;
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle();
    chk("reset_busy", 32'(FDivBusyE), 0);
    chk("reset_done", 32'(FDivDoneE), 0);
    chk("reset_step", 32'(StepE), 0);

    // CyclesE=5, no early exit: done six cycles after the start cycle
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5);
    chk("t1_start", 32'(IFDivStartE), 1);
    chk("t1_busy0", 32'(FDivBusyE), 1);
    for (int k = 1; k <= 5; k++) begin
      idle();
      chk("t1_step", 32'(StepE), 32'(6 - k));
      chk("t1_busy", 32'(FDivBusyE), 1);
      chk("t1_first", 32'(FirstIterE), 32'(k == 1));
      chk("t1_nodone", 32'(FDivDoneE), 0);
    end
    idle();
    chk("t1_done", 32'(FDivDoneE), 1);
    chk("t1_step0", 32'(StepE), 0);
    idle();
    chk("t1_idle", 32'(FDivDoneE), 0);

    // CyclesE=20, zero residual on BUSY cycle 3
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20);
    idle();
    idle();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    chk("t2_step3", 32'(StepE), 18);
    idle();
    chk("t2_done", 32'(FDivDoneE), 1);
    chk("t2_step0", 32'(StepE), 0);
    idle();
    chk("t2_idle", 32'(FDivDoneE), 0);

    // special case bypasses iteration entirely
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 20);
    chk("t3_start", 32'(IFDivStartE), 1);
    idle();
    chk("t3_done", 32'(FDivDoneE), 1);
    chk("t3_first", 32'(FirstIterE), 0);
    chk("t3_step", 32'(StepE), 0);
    idle();

    // result held through four stalled cycles
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    idle();
    idle();
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      chk("t4_held", 32'(FDivDoneE), 1);
    end
    idle();
    chk("t4_last", 32'(FDivDoneE), 1);
    idle();
    chk("t4_idle", 32'(FDivDoneE), 0);

    // flush on BUSY cycle 2, then a fresh start is accepted
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10);
    idle();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    chk("t5_step0", 32'(StepE), 0);
    chk("t5_nodone", 32'(FDivDoneE), 0);
    chk("t5_restart", 32'(IFDivStartE), 1);
    idle();
    chk("t5_step", 32'(StepE), 3);
    for (int k = 0; k < 4; k++) idle();

    // reset mid-iteration, then a start held off by StallM
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10);
    idle();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle();
    chk("t6_start", 32'(IFDivStartE), 0);
    chk("t6_busy", 32'(FDivBusyE), 0);
    chk("t6_done", 32'(FDivDoneE), 0);
    chk("t6_first", 32'(FirstIterE), 0);
    chk("t6_step", 32'(StepE), 0);
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
      chk("t6_stalled", 32'(IFDivStartE), 0);
    end
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    chk("t6_go", 32'(IFDivStartE), 1);
    idle();
    idle();
    idle();

    // CyclesE=0 behaves as 1; both start sources count once
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("t7_start", 32'(IFDivStartE), 1);
    idle();
    chk("t7_step", 32'(StepE), 1);
    chk("t7_first", 32'(FirstIterE), 1);
    idle();
    chk("t7_done", 32'(FDivDoneE), 1);
    idle();

    for (int it = 0; it < 3000; it++) begin
      bit r, f, i, s, fl, sp, w;
      int n;
      r  = ($urandom_range(0, 255) == 0);
      f  = ($urandom_range(0, 2) == 0);
      i  = ($urandom_range(0, 4) == 0);
      s  = ($urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 31) == 0);
      sp = ($urandom_range(0, 7) == 0);
      w  = ($urandom_range(0, 11) == 0);
      n  = ($urandom_range(0, 49) == 0) ? 127 : int'($urandom_range(0, 12));
      apply(r, f, i, s, fl, sp, w, n);
    end

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fdivsqrt_seq.md
Name: fdivsqrt_seq

Overview:
- Iteration sequencer for the shared divide/square-root datapath (FP div, FP sqrt, integer div/rem).
- Accepts a start request, loads the precomputed iteration count, and steps the digit-recurrence loop in the Execute stage.
- Terminates early on an exact (zero-residual) result and bypasses iteration on special cases.
- Holds the completed result until the Memory stage can accept it.

Parameters:
- CNTW, 7, width of the iteration step counter; must hold the maximum cycle count for the widest format or XLEN integer divide.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- FDivStartE  in  1  FP divide/sqrt request in Execute
- IDivStartE  in  1  integer divide/remainder request in Execute
- StallM  in  1  Memory stage stalled
- FlushE  in  1  flush of the Execute stage
- SpecialCaseE  in  1  NaN/Inf/zero/div-by-zero/small-numerator case; no iteration required
- WZeroE  in  1  residual is exactly zero (early-termination detect)
- CyclesE  in  CNTW  iteration count for the current operation, valid while a start is asserted
- IFDivStartE  out  1  one-cycle load strobe to the datapath (initial residual/quotient registers)
- FDivBusyE  out  1  unit occupied; holds the upstream pipeline
- FDivDoneE  out  1  result is final and waiting for Memory
- FirstIterE  out  1  first iteration cycle; feeds the first-digit/Firstun qualification
- StepE  out  CNTW  remaining iteration count, for debug and coverage

Behaviour:
- States: IDLE, BUSY, DONE. Encoding goes in the shared package.
- Reset:
  - state goes to IDLE, StepE to 0.
  - All outputs are 0 in the cycle after reset is sampled.
- Combinational outputs:
  - IFDivStartE = (FDivStartE | IDivStartE) & (state==IDLE) & ~StallM & ~FlushE
  - FDivBusyE = (state==BUSY) | IFDivStartE. Busy is asserted in the start cycle so that no new instruction enters Execute.
  - FDivDoneE = (state==DONE)
  - FirstIterE = (state==BUSY) & first-cycle flag. The flag is a register set on the IFDivStartE edge and cleared after one BUSY cycle.
- IDLE:
  - If IFDivStartE & SpecialCaseE: go to DONE. Zero iterations; StepE is loaded with 0.
  - Else if IFDivStartE: go to BUSY, StepE <= max(CyclesE,1). A CyclesE of 0 is treated as 1.
  - Otherwise stay in IDLE.
- BUSY:
  - If StepE==1 or WZeroE: go to DONE, StepE <= 0.
  - Else StepE <= StepE-1.
  - WZeroE is sampled on every BUSY cycle, including the first.
- DONE:
  - If StallM: stay in DONE and hold FDivDoneE.
  - Else return to IDLE. A new start is accepted no earlier than the next cycle; there is no back-to-back start out of DONE.
- FlushE:
  - Forces IDLE from any state in the next cycle and clears StepE and the first flag.
  - Priority: reset > FlushE > state logic.
- Start requests while BUSY or DONE are ignored. The requester holds its request until IFDivStartE is seen.
- Latency, start cycle to FDivDoneE:
  - N+1 cycles for CyclesE=N with no early exit.
  - 1 cycle for a special case.
  - k+1 cycles when WZeroE is asserted on the k-th BUSY cycle.
- Simultaneous FDivStartE and IDivStartE are illegal (one decoder source). The block treats them as a single start.
- StepE decrements by exactly 1 per BUSY cycle and never wraps below 0.

Decomposition:
- Shared package holds:
  - the fdivsqrt_state_t enum (IDLE, BUSY, DONE);
  - the CNTW derivation from the configuration, i.e. max(format cycles, XLEN/LOGR integer cycles).
- CyclesE computation stays in the preprocessing block, not here.
- One natural sub-module: fdivsqrt_stepcnt, a loadable down-counter with a ==1 detect and synchronous clear.

Test Plan:
- Start with CyclesE=5, WZeroE=0, StallM=0:
  - IFDivStartE pulses once.
  - BUSY lasts 5 cycles; StepE runs 5,4,3,2,1.
  - FDivDoneE rises in cycle 6, then IDLE.
- Start with CyclesE=20, WZeroE rising on BUSY cycle 3: DONE entered after cycle 3, StepE=0, FDivDoneE asserted in cycle 4.
- Start with SpecialCaseE=1, CyclesE=20: IDLE goes to DONE in 1 cycle, FirstIterE never asserted.
- Completion with StallM=1 for 4 cycles: FDivDoneE held for 4 cycles, then IDLE one cycle after StallM falls.
- FlushE on BUSY cycle 2 of CyclesE=10: IDLE next cycle, StepE=0, FDivDoneE never asserted, and a new start is accepted.
- Reset asserted during BUSY, plus a start while StallM=1 in IDLE:
  - After reset, all outputs are 0.
  - With StallM=1, no IFDivStartE occurs until StallM falls.
